// File: rtl/card_rom_pkg.sv
// card_rom_pkg: shared state type and default sizing for the
// card image ROM read-port arbiter.
package card_rom_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_BURST_MAX  = 16;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/card_rom_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting one past
// last_owner, wrapping at N_REQ-1.
module rr_picker
  import card_rom_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = idw(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic             any,
  output logic [IW-1:0]    winner
);

  logic [IW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_owner) + k) % N_REQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/card_rom_arbiter.sv
// card_rom_arbiter: round-robin burst arbiter sharing one
// 1-cycle registered card image ROM read port.
module card_rom_arbiter
  import card_rom_pkg::*;
#(
  parameter  int N_REQ      = DEF_N_REQ,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int BURST_MAX  = DEF_BURST_MAX,
  localparam int IW         = idw(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  output logic [N_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  input  logic [DATA_WIDTH-1:0]       rom_dout,
  output logic                        rd_valid,
  output logic [IW-1:0]               rd_id,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_MAX - 1);

  arb_state_e    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;
  logic [CW-1:0] beats;

  logic          beat;
  logic          rel;
  logic          any;
  logic [IW-1:0] winner;
  logic [IW-1:0] from;

  assign beat = (state == GRANT) && req[owner];
  assign rel  = (state == GRANT) &&
                (!req[owner] || (beats == LAST));

  // On release the search starts after the current owner, so
  // a lone requester wraps around to itself with no gap.
  assign from = (state == GRANT) ? owner : last_owner;

  rr_picker #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req       (req),
    .last_owner(from),
    .any       (any),
    .winner    (winner)
  );

  always_comb begin
    gnt = '0;
    if (state == GRANT) gnt[owner] = 1'b1;
  end

  always_comb begin
    rom_addr = '0;
    if (!rst && state == GRANT)
      rom_addr = addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign rd_data = rom_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(N_REQ - 1);
      beats      <= '0;
      rd_valid   <= 1'b0;
      rd_id      <= '0;
    end else begin
      rd_valid <= beat;
      rd_id    <= owner;
      unique case (state)
        IDLE: begin
          if (any) begin
            state <= GRANT;
            owner <= winner;
            beats <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            last_owner <= owner;
            beats      <= '0;
            if (any) owner <= winner;
            else     state <= IDLE;
          end else if (beat) begin
            beats <= beats + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/card_rom_arbiter.md
CARD_ROM_ARBITER -- requirements
Module: card_rom_arbiter

Interface
REQ-001 Parameters SHALL be N_REQ, default 4, number of requesters sharing one card image ROM read port.
REQ-002 Parameters SHALL include ADDR_WIDTH, default 13, ROM address width.
REQ-003 Parameters SHALL include DATA_WIDTH, default 12, ROM pixel width (RGB444).
REQ-004 Parameters SHALL include BURST_MAX, default 16, maximum beats per grant before forced rotation.
REQ-005 Ports SHALL be, in order:
- clk  in  1  posedge clock, single clock domain.
- rst  in  1  synchronous active-high reset.
- req  in  N_REQ  per-requester read request.
- addr  in  N_REQ*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  out  N_REQ  one-hot grant, registered.
- rom_addr  out  ADDR_WIDTH  address to ROM.
- rom_dout  in  DATA_WIDTH  ROM data, registered one cycle after rom_addr.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_id  out  $clog2(N_REQ)  requester owning rd_data.
- rd_data  out  DATA_WIDTH  returned pixel.

Function
REQ-006 The FSM SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-007 Arbitration SHALL be round-robin, searching from last_owner+1 upward with wrap at N_REQ-1 -> 0; the first requester with req=1 wins.
REQ-008 From IDLE, any req=1 SHALL load owner and enter GRANT on the next edge; gnt[owner] rises that edge.
REQ-009 gnt SHALL be a function of registered state only: gnt[i]=1 iff state=GRANT and owner=i; at most one bit set.
REQ-010 rom_addr SHALL be addr[owner] combinationally in GRANT, and 0 in IDLE.
REQ-011 A beat SHALL be issued in each GRANT cycle where req[owner]=1; the beat counter increments per beat.
REQ-012 rd_valid and rd_id SHALL be registered copies of (beat issued, owner), so they rise exactly 1 cycle after the beat; rd_data SHALL equal rom_dout combinationally; total latency is 1 cycle.
REQ-013 Release SHALL occur at the end of a GRANT cycle if req[owner]=0 (no beat issued), or if this cycle's beat is the BURST_MAX-th.
REQ-014 On release, last_owner SHALL take owner and the beat counter SHALL clear; arbitration of REQ-007 runs in the same cycle with no bubble.
REQ-015 On release, if any req=1 (excluding the releasing owner when its req=0), the FSM SHALL stay in GRANT with the new owner; otherwise it SHALL enter IDLE.
REQ-016 A sole requester hitting BURST_MAX with req still 1 SHALL be re-granted itself without a gap.
REQ-017 The beat counter SHALL be $clog2(BURST_MAX+1) bits and SHALL never exceed BURST_MAX.
REQ-018 A requester SHALL hold addr stable only in cycles where req=1 and gnt=1; the arbiter never stores addresses.
REQ-019 Requests changing while another requester owns the grant SHALL have no effect until release.

Reset
REQ-020 rst=1 at an edge SHALL force state=IDLE, gnt=0, rd_valid=0, rd_id=0, beat counter=0, and last_owner=N_REQ-1 (requester 0 wins first).
REQ-021 Reset mid-burst SHALL drop gnt at that edge and suppress rd_valid for the beat issued in the cycle before reset; that data is discarded.
REQ-022 rom_addr SHALL be 0 while in reset and until the first grant.

Structure
REQ-023 Package card_rom_pkg SHALL hold the state enum (IDLE, GRANT) and default constants (N_REQ, ADDR_WIDTH, DATA_WIDTH, BURST_MAX).
REQ-024 The round-robin search SHALL be a combinational sub-module rr_picker (inputs req, last_owner; outputs any, winner).
REQ-025 The block SHALL be synthesizable and connect directly to image_rom_card-style ROMs (1-cycle registered read).

Verification
REQ-026 Single req[2]=1 held 5 cycles after reset: gnt=0100 from cycle 1; rd_valid on cycles 2..6 with rd_id=2 and rd_data=ROM[addr] from the prior cycle.
REQ-027 req=1111 held: grants go 0,1,2,3,0 with 16 beats each, no idle cycles between owners.
REQ-028 Owner 1 drops req after 3 beats while req[3]=1: the next edge gives gnt=1000; exactly 3 rd_valid with rd_id=1.
REQ-029 Only req[0] held 40 cycles: continuous beats, rd_valid never drops after the first, owner stays 0 across the BURST_MAX wrap.
REQ-030 rst pulsed on the 5th beat of a burst: the next cycle has gnt=0 and rd_valid=0; after release, requester 0 has priority again.
REQ-031 A ROM model returning addr as data with random req patterns: a scoreboard checks every rd_data/rd_id pair against the issued address, and checks gnt is one-hot or zero every cycle.
